// File: rtl/cond_flags_stage.sv
// ============================================================================
//  Module   : cond_flags_stage
//  Brief    : Execute-commit stage. Holds NZCV, evaluates condition codes,
//             commits flags and registers the ALU result toward writeback.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cond_flags_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst,
    input  logic [31:0]      alu_out,
    input  logic             update_CPSR,
    input  logic             ignore_C_flag,
    input  logic             N_flag,
    input  logic             Z_flag,
    input  logic             C_flag,
    input  logic             V_flag,
    input  logic             flush,
    output logic [3:0]       cpsr_nzcv,
    output logic             cpsr_c,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic             wb_we,
    output logic [3:0]       wb_addr,
    output logic [31:0]      wb_data,
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] skip_cnt
);

    localparam logic [3:0]       c_OP_TST  = 4'b1000;
    localparam logic [3:0]       c_OP_TEQ  = 4'b1001;
    localparam logic [3:0]       c_OP_CMP  = 4'b1010;
    localparam logic [3:0]       c_OP_CMN  = 4'b1011;
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0]       nzcv_q,     nzcv_d;
    logic             wb_valid_q, wb_valid_d;
    logic             wb_we_q,    wb_we_d;
    logic [3:0]       wb_addr_q,  wb_addr_d;
    logic [31:0]      wb_data_q,  wb_data_d;
    logic [CNT_W-1:0] exec_cnt_q, exec_cnt_d;
    logic [CNT_W-1:0] skip_cnt_q, skip_cnt_d;

    logic             w_accept;
    logic             w_cond_pass;
    logic             w_is_compare;
    logic             w_n, w_z, w_c, w_v;
    logic             w_unused_bits;

    assign w_unused_bits = ^{inst[27:25], inst[20:16], inst[11:0]};

    assign {w_n, w_z, w_c, w_v} = nzcv_q;
    assign in_ready = !wb_valid_q || wb_ready;
    assign w_accept = in_valid && in_ready && !flush;

    always_comb begin
        w_cond_pass = 1'b0;
        case (inst[31:28])
            4'h0:    w_cond_pass = w_z;
            4'h1:    w_cond_pass = !w_z;
            4'h2:    w_cond_pass = w_c;
            4'h3:    w_cond_pass = !w_c;
            4'h4:    w_cond_pass = w_n;
            4'h5:    w_cond_pass = !w_n;
            4'h6:    w_cond_pass = w_v;
            4'h7:    w_cond_pass = !w_v;
            4'h8:    w_cond_pass = w_c && !w_z;
            4'h9:    w_cond_pass = !w_c || w_z;
            4'hA:    w_cond_pass = (w_n == w_v);
            4'hB:    w_cond_pass = (w_n != w_v);
            4'hC:    w_cond_pass = !w_z && (w_n == w_v);
            4'hD:    w_cond_pass = w_z || (w_n != w_v);
            4'hE:    w_cond_pass = 1'b1;
            default: w_cond_pass = 1'b0;
        endcase
    end

    always_comb begin
        w_is_compare = 1'b0;
        case (inst[24:21])
            c_OP_TST, c_OP_TEQ, c_OP_CMP, c_OP_CMN: w_is_compare = 1'b1;
            default:                                w_is_compare = 1'b0;
        endcase
    end

    always_comb begin
        nzcv_d     = nzcv_q;
        wb_valid_d = wb_valid_q;
        wb_we_d    = wb_we_q;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        exec_cnt_d = exec_cnt_q;
        skip_cnt_d = skip_cnt_q;

        if (flush) begin
            wb_valid_d = 1'b0;
        end else if (w_accept) begin
            wb_valid_d = 1'b1;
            wb_addr_d  = inst[15:12];
            wb_data_d  = alu_out;
            if (w_cond_pass) begin
                wb_we_d = !w_is_compare;
                if (update_CPSR) begin
                    nzcv_d = {N_flag, Z_flag, (ignore_C_flag ? w_c : C_flag), V_flag};
                end
                if (exec_cnt_q != c_CNT_MAX) begin
                    exec_cnt_d = exec_cnt_q + c_CNT_ONE;
                end
            end else begin
                wb_we_d = 1'b0;
                if (skip_cnt_q != c_CNT_MAX) begin
                    skip_cnt_d = skip_cnt_q + c_CNT_ONE;
                end
            end
        end else if (wb_valid_q && wb_ready) begin
            wb_valid_d = 1'b0;
        end
    end

    // Reset discards any entry still waiting for the writeback consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nzcv_q     <= 4'b0000;
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_addr_q  <= 4'h0;
            wb_data_q  <= 32'h0;
            exec_cnt_q <= '0;
            skip_cnt_q <= '0;
        end else begin
            nzcv_q     <= nzcv_d;
            wb_valid_q <= wb_valid_d;
            wb_we_q    <= wb_we_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            exec_cnt_q <= exec_cnt_d;
            skip_cnt_q <= skip_cnt_d;
        end
    end

    assign cpsr_nzcv = nzcv_q;
    assign cpsr_c    = nzcv_q[1];
    assign wb_valid  = wb_valid_q;
    assign wb_we     = wb_we_q;
    assign wb_addr   = wb_addr_q;
    assign wb_data   = wb_data_q;
    assign exec_cnt  = exec_cnt_q;
    assign skip_cnt  = skip_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_cond_flags_stage.sv
// ============================================================================
//  Module   : tb_cond_flags_stage
//  Brief    : Self-checking bench for cond_flags_stage (vector table plus
//             writeback scoreboard and hand-written corner sequences).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cond_flags_stage;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      inst;
    logic [31:0]      alu_out;
    logic             update_CPSR;
    logic             ignore_C_flag;
    logic             N_flag, Z_flag, C_flag, V_flag;
    logic             flush;
    logic [3:0]       cpsr_nzcv;
    logic             cpsr_c;
    logic             wb_valid;
    logic             wb_ready;
    logic             wb_we;
    logic [3:0]       wb_addr;
    logic [31:0]      wb_data;
    logic [CNT_W-1:0] exec_cnt;
    logic [CNT_W-1:0] skip_cnt;

    always #5 clk = ~clk;

    cond_flags_stage #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .inst          (inst),
        .alu_out       (alu_out),
        .update_CPSR   (update_CPSR),
        .ignore_C_flag (ignore_C_flag),
        .N_flag        (N_flag),
        .Z_flag        (Z_flag),
        .C_flag        (C_flag),
        .V_flag        (V_flag),
        .flush         (flush),
        .cpsr_nzcv     (cpsr_nzcv),
        .cpsr_c        (cpsr_c),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_we         (wb_we),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .exec_cnt      (exec_cnt),
        .skip_cnt      (skip_cnt)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] alu;
        logic        upd;
        logic        ignc;
        logic [3:0]  fl;
        logic [3:0]  exp_nzcv;
        logic        exp_we;
    } vec_t;

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [31:0] data;
    } wb_t;

    wb_t              exp_q[$];
    vec_t             vecs[15];
    int               n_cmp = 0;
    int               n_bad = 0;
    logic [3:0]       m_nzcv;
    logic             m_valid;
    logic [CNT_W-1:0] m_exec;
    logic [CNT_W-1:0] m_skip;

    function automatic logic [31:0] mk_inst(input logic [3:0] c, input logic [3:0] opc,
                                            input logic [3:0] rd);
        return {c, 3'b000, opc, 1'b1, 4'h0, rd, 12'h000};
    endfunction

    function automatic vec_t mkv(input logic [3:0] c, input logic [3:0] opc,
                                 input logic [3:0] rd, input logic [31:0] alu,
                                 input logic upd, input logic ignc, input logic [3:0] fl,
                                 input logic [3:0] exp_nzcv, input logic exp_we);
        vec_t v;
        v.inst = mk_inst(c, opc, rd);
        v.alu = alu; v.upd = upd; v.ignc = ignc; v.fl = fl;
        v.exp_nzcv = exp_nzcv; v.exp_we = exp_we;
        return v;
    endfunction

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cf && !z;
            4'h9: return !cf || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] a, input logic upd,
                         input logic ignc, input logic [3:0] fl);
        inst = i; alu_out = a; update_CPSR = upd; ignore_C_flag = ignc;
        {N_flag, Z_flag, C_flag, V_flag} = fl;
    endtask

    task automatic model_clear();
        m_nzcv = 4'b0000; m_valid = 1'b0; m_exec = '0; m_skip = '0;
        exp_q.delete();
    endtask

    // Called one time unit after a rising edge; returns one unit after the next.
    task automatic cycle();
        wb_t  e;
        logic rdy, acc, pass, cmp;
        #3;
        rdy = !m_valid || wb_ready;
        chk("in_ready", {31'b0, in_ready}, {31'b0, rdy});
        acc = in_valid && rdy && !flush;
        if (m_valid && exp_q.size() > 0) begin
            e = exp_q[0];
            chk("pre_wb_we",   {31'b0, wb_we},   {31'b0, e.we});
            chk("pre_wb_addr", {28'b0, wb_addr}, {28'b0, e.addr});
            chk("pre_wb_data", wb_data, e.data);
            if (wb_ready || flush) void'(exp_q.pop_front());
        end
        if (acc) begin
            pass = cond_ok(inst[31:28], m_nzcv);
            cmp  = (inst[24:21] inside {4'b1000, 4'b1001, 4'b1010, 4'b1011});
            e.we = pass && !cmp; e.addr = inst[15:12]; e.data = alu_out;
            exp_q.push_back(e);
            if (pass) begin
                if (update_CPSR)
                    m_nzcv = {N_flag, Z_flag, (ignore_C_flag ? m_nzcv[1] : C_flag), V_flag};
                if (m_exec != '1) m_exec = m_exec + 1'b1;
            end else begin
                if (m_skip != '1) m_skip = m_skip + 1'b1;
            end
        end
        if (flush)                    m_valid = 1'b0;
        else if (acc)                 m_valid = 1'b1;
        else if (m_valid && wb_ready) m_valid = 1'b0;
        @(posedge clk); #1;
        chk("cpsr_nzcv", {28'b0, cpsr_nzcv}, {28'b0, m_nzcv});
        chk("cpsr_c",    {31'b0, cpsr_c},    {31'b0, m_nzcv[1]});
        chk("exec_cnt",  32'(exec_cnt),      32'(m_exec));
        chk("skip_cnt",  32'(skip_cnt),      32'(m_skip));
        chk("wb_valid",  {31'b0, wb_valid},  {31'b0, m_valid});
        if (m_valid && exp_q.size() > 0) begin
            chk("wb_we",   {31'b0, wb_we},   {31'b0, exp_q[0].we});
            chk("wb_addr", {28'b0, wb_addr}, {28'b0, exp_q[0].addr});
            chk("wb_data", wb_data, exp_q[0].data);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_nzcv"},  {28'b0, cpsr_nzcv}, 32'h0);
        chk({tag, "_valid"}, {31'b0, wb_valid},  32'h0);
        chk({tag, "_we"},    {31'b0, wb_we},     32'h0);
        chk({tag, "_addr"},  {28'b0, wb_addr},   32'h0);
        chk({tag, "_data"},  wb_data,            32'h0);
        chk({tag, "_exec"},  32'(exec_cnt),      32'h0);
        chk({tag, "_skip"},  32'(skip_cnt),      32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // {cond, opcode, rd, alu, upd, ignc, NZCV in, expected NZCV, expected we}
        vecs[0]  = mkv(4'hE, 4'b0100, 4'd1,  32'h0000_0000, 1, 0, 4'b0110, 4'b0110, 1);
        vecs[1]  = mkv(4'h1, 4'b1101, 4'd2,  32'h0000_0011, 0, 0, 4'b0000, 4'b0110, 0);
        vecs[2]  = mkv(4'h0, 4'b1101, 4'd3,  32'h0000_0055, 0, 0, 4'b0000, 4'b0110, 1);
        vecs[3]  = mkv(4'hE, 4'b1101, 4'd4,  32'h0000_1234, 1, 1, 4'b0000, 4'b0010, 1);
        vecs[4]  = mkv(4'hE, 4'b1010, 4'd0,  32'hFFFF_FFF0, 1, 1, 4'b1001, 4'b1011, 0);
        vecs[5]  = mkv(4'hA, 4'b1101, 4'd5,  32'h0000_00A5, 0, 0, 4'b0000, 4'b1011, 1);
        vecs[6]  = mkv(4'hB, 4'b1101, 4'd6,  32'h0000_00B6, 0, 0, 4'b0000, 4'b1011, 0);
        vecs[7]  = mkv(4'h8, 4'b0100, 4'd7,  32'h0000_0000, 1, 0, 4'b0100, 4'b0100, 1);
        vecs[8]  = mkv(4'h9, 4'b1101, 4'd8,  32'h0000_0088, 0, 0, 4'b0000, 4'b0100, 1);
        vecs[9]  = mkv(4'hC, 4'b1000, 4'd0,  32'h0000_0000, 1, 0, 4'b0001, 4'b0100, 0);
        vecs[10] = mkv(4'hF, 4'b0100, 4'd9,  32'h0000_0099, 1, 0, 4'b1111, 4'b0100, 0);
        vecs[11] = mkv(4'hE, 4'b1011, 4'd0,  32'h0000_0000, 1, 0, 4'b1111, 4'b1111, 0);
        vecs[12] = mkv(4'hD, 4'b1101, 4'd9,  32'h0000_0D09, 0, 0, 4'b0000, 4'b1111, 1);
        vecs[13] = mkv(4'h7, 4'b1101, 4'd10, 32'h0000_070A, 0, 0, 4'b0000, 4'b1111, 0);
        vecs[14] = mkv(4'h4, 4'b1101, 4'd10, 32'h0000_040A, 0, 0, 4'b0000, 4'b1111, 1);

        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; wb_ready = 1'b1;
        drive(32'h0, 32'h0, 1'b0, 1'b0, 4'b0000);
        model_clear();
        #12;
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        in_valid = 1'b1;
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].inst, vecs[i].alu, vecs[i].upd, vecs[i].ignc, vecs[i].fl);
            cycle();
            chk("tbl_nzcv", {28'b0, cpsr_nzcv}, {28'b0, vecs[i].exp_nzcv});
            chk("tbl_we",   {31'b0, wb_we},     {31'b0, vecs[i].exp_we});
        end

        // Stall three cycles, then drain and accept on the same edge.
        wb_ready = 1'b0;
        drive(mk_inst(4'hE, 4'b1101, 4'd11), 32'h0000_BEEF, 1'b0, 1'b0, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_data", wb_data, 32'h0000_040A);
        end
        wb_ready = 1'b1;
        cycle();
        chk("drain_acc_valid", {31'b0, wb_valid}, 32'h1);
        chk("drain_acc_data",  wb_data, 32'h0000_BEEF);
        chk("drain_acc_addr",  {28'b0, wb_addr}, 32'd11);

        // Flush beats a simultaneous flag-setting accept.
        drive(mk_inst(4'hE, 4'b0100, 4'd12), 32'h0000_1212, 1'b1, 1'b0, 4'b1000);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("flush_valid", {31'b0, wb_valid}, 32'h0);
        chk("flush_nzcv",  {28'b0, cpsr_nzcv}, 32'hF);

        // Flush clears a held entry even when the consumer is stalled.
        drive(mk_inst(4'hE, 4'b1101, 4'd13), 32'h0000_0077, 1'b0, 1'b0, 4'b0000);
        cycle();
        in_valid = 1'b0; wb_ready = 1'b0; flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("flush_stall_valid", {31'b0, wb_valid}, 32'h0);

        // Asynchronous reset in the middle of a stall.
        in_valid = 1'b1; wb_ready = 1'b1;
        cycle();
        wb_ready = 1'b0;
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        model_clear();
        in_valid = 1'b0; wb_ready = 1'b1;
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Seventeen never-condition instructions saturate the 4-bit skip counter.
        in_valid = 1'b1;
        drive(mk_inst(4'hF, 4'b1101, 4'd14), 32'h0000_00EE, 1'b1, 1'b0, 4'b1111);
        for (int i = 0; i < 17; i++) cycle();
        chk("skip_sat", 32'(skip_cnt), 32'hF);
        chk("skip_sat_nzcv", {28'b0, cpsr_nzcv}, 32'h0);
        in_valid = 1'b0;
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
